// File: rtl/game_pkg.sv
// Shared game-wide types and screen geometry for the banner sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SLIDE_IN  = 2'd1,
    HOLD      = 2'd2,
    SLIDE_OUT = 2'd3
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/banner_hold_timer.sv
// Frame counter for the banner HOLD phase; blink_on/expired describe the
// count the next tick will produce, so the FSM can act on that same tick.
module banner_hold_timer #(
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_PERIOD = 16,
  parameter int CNT_W        = $clog2(HOLD_FRAMES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic blink_on,
  output logic expired
);

  localparam int PH_W = $clog2(BLINK_PERIOD);

  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cnt_nx;

  assign cnt_nx = hold_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clear) hold_cnt <= '0;
    else if (tick)    hold_cnt <= cnt_nx;
  end

  // Power-of-two period: first half of each period is the top phase bit at 0.
  assign blink_on = ~cnt_nx[PH_W-1];
  assign expired  = (cnt_nx == CNT_W'(HOLD_FRAMES));

endmodule

// File: rtl/ack_banner_seq.sv
// Acknowledgement banner sequencer: slide in, blink-hold, slide out.
// All motion is gated by frame_tick so the renderer never sees a mid-frame move.
module ack_banner_seq
  import game_pkg::*;
#(
  parameter int WIDTH        = 170,
  parameter int HOME_X       = (SCREEN_W - WIDTH) / 2,
  parameter int HOME_Y       = 100,
  parameter int OFF_X        = SCREEN_W,
  parameter int STEP         = 4,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       skip,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       isplay,
  output logic       busy,
  output logic       done
);

  localparam logic [10:0] HOME_X11 = 11'(HOME_X);
  localparam logic [10:0] OFF_X11  = 11'(OFF_X);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [9:0]  HOME_X10 = 10'(HOME_X);
  localparam logic [9:0]  OFF_X10  = 10'(OFF_X);
  localparam logic [9:0]  STEP10   = 10'(STEP);
  localparam logic [8:0]  HOME_Y9  = 9'(HOME_Y);

  state_t      state;
  logic        skip_pend;
  logic        blink_on;
  logic        expired;
  logic [10:0] px;
  logic [10:0] gap;
  logic [10:0] sum;
  logic        skip_now;

  // 11-bit arithmetic keeps posx+STEP from wrapping near OFF_X.
  assign px       = {1'b0, posx};
  assign gap      = px - HOME_X11;
  assign sum      = px + STEP11;
  assign skip_now = skip_pend | skip;

  banner_hold_timer #(
    .HOLD_FRAMES  (HOLD_FRAMES),
    .BLINK_PERIOD (BLINK_PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != HOLD),
    .tick     (frame_tick && (state == HOLD)),
    .blink_on (blink_on),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      posx      <= OFF_X10;
      posy      <= HOME_Y9;
      isplay    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      skip_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      posy <= HOME_Y9;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SLIDE_IN;
            posx      <= OFF_X10;
            isplay    <= 1'b1;
            busy      <= 1'b1;
            skip_pend <= 1'b0;
          end
        end
        SLIDE_IN: begin
          if (frame_tick) begin
            // A pending skip leaves from the current position without stepping.
            if (skip_now) begin
              state     <= SLIDE_OUT;
              skip_pend <= 1'b0;
            end else if (gap <= STEP11) begin
              posx  <= HOME_X10;
              state <= HOLD;
            end else begin
              posx <= posx - STEP10;
            end
          end else if (skip) begin
            skip_pend <= 1'b1;
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (expired || skip_now) begin
              state     <= SLIDE_OUT;
              isplay    <= 1'b1;
              skip_pend <= 1'b0;
            end else begin
              isplay <= blink_on;
            end
          end else if (skip) begin
            skip_pend <= 1'b1;
          end
        end
        SLIDE_OUT: begin
          if (frame_tick) begin
            if (sum >= OFF_X11) begin
              posx   <= OFF_X10;
              isplay <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              posx <= posx + STEP10;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ack_banner_seq.sv
// Bench for ack_banner_seq: directed scenario tasks plus a randomized run
// against a frame-level reference model of the banner sequence.
module tb_ack_banner_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       skip = 1'b0;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       isplay;
  logic       busy;
  logic       done;

  int errs = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 sliding in, 2 holding, 3 sliding out.
  int m_phase = 0;
  int m_x = 640;
  int m_hc = 0;
  bit m_pend = 0;
  bit m_vis = 0;
  bit m_done = 0;

  ack_banner_seq dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .skip       (skip),
    .posx       (posx),
    .posy       (posy),
    .isplay     (isplay),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step(input bit t, input bit s, input bit k, input bit r);
    frame_tick = t; start = s; skip = k; rst = r;
    @(posedge clk);
    m_done = 0;
    if (r) begin
      m_phase = 0; m_x = 640; m_hc = 0; m_pend = 0; m_vis = 0;
    end else if (m_phase == 0) begin
      if (s) begin m_phase = 1; m_x = 640; m_vis = 1; m_pend = 0; end
    end else if (m_phase == 1) begin
      if (t) begin
        if (m_pend || k) begin m_phase = 3; m_pend = 0; end
        else if (m_x - 235 <= 4) begin m_x = 235; m_phase = 2; m_hc = 0; end
        else m_x = m_x - 4;
      end else if (k) m_pend = 1;
    end else if (m_phase == 2) begin
      if (t) begin
        m_hc++;
        if (m_hc == 120 || m_pend || k) begin m_phase = 3; m_vis = 1; m_pend = 0; end
        else m_vis = (m_hc % 16) < 8;
      end else if (k) m_pend = 1;
    end else begin
      if (t) begin
        if (m_x + 4 >= 640) begin m_x = 640; m_vis = 0; m_phase = 0; m_done = 1; end
        else m_x = m_x + 4;
      end
    end
    #1;
    frame_tick = 0; start = 0; skip = 0; rst = 0;
  endtask

  // Idle cycles then one frame_tick; outputs afterwards reflect that tick.
  task automatic tick_after(input int gap);
    repeat (gap - 1) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic run_to_hold();
    step(0, 1, 0, 0);
    for (int i = 0; i < 102; i++) tick_after(2);
  endtask

  task automatic finish_out();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin tick_after(2); n++; end
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL finish_timeout: busy=%b after %0d ticks, want 0", busy, n); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    checks++; if (posx !== 10'd640) begin errs++; $display("FAIL reset_posx: got %0d want 640", posx); end
    checks++; if (posy !== 9'd100) begin errs++; $display("FAIL reset_posy: got %0d want 100", posy); end
    checks++; if ({isplay, busy, done} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {isplay, busy, done}); end
    run_to_hold();
    repeat (3) tick_after(2);
    checks++; if (busy !== 1'b1 || posx !== 10'd235) begin errs++; $display("FAIL pre_reset_hold: busy=%b posx=%0d want 1/235", busy, posx); end
    repeat (3) step(0, 0, 0, 1);
    checks++; if (posx !== 10'd640 || posy !== 9'd100) begin errs++; $display("FAIL midreset_pos: got %0d/%0d want 640/100", posx, posy); end
    checks++; if ({isplay, busy, done} !== 3'b000) begin errs++; $display("FAIL midreset_flags: got %b want 000", {isplay, busy, done}); end
    step(1, 0, 0, 0);
    checks++; if (busy !== 1'b0 || posx !== 10'd640) begin errs++; $display("FAIL post_reset_idle: busy=%b posx=%0d want 0/640", busy, posx); end
  endtask

  task automatic test_full_run();
    int dcnt;
    bit exp_vis;
    step(0, 1, 0, 0);
    checks++; if ({isplay, busy} !== 2'b11 || posx !== 10'd640) begin errs++; $display("FAIL full_start: isplay/busy=%b posx=%0d want 11/640", {isplay, busy}, posx); end
    for (int i = 1; i <= 102; i++) begin
      tick_after(10);
      if (i == 101) begin checks++; if (posx !== 10'd236) begin errs++; $display("FAIL full_tick101: got %0d want 236", posx); end end
      if (i == 102) begin checks++; if (posx !== 10'd235) begin errs++; $display("FAIL full_tick102: got %0d want 235", posx); end end
    end
    for (int k = 1; k <= 120; k++) begin
      tick_after(10);
      exp_vis = (k == 120) ? 1'b1 : ((k % 16) < 8);
      checks++; if (isplay !== exp_vis || posx !== 10'd235) begin errs++; $display("FAIL full_hold_%0d: isplay=%b posx=%0d want %b/235", k, isplay, posx, exp_vis); end
    end
    dcnt = 0;
    for (int i = 1; i <= 102; i++) begin
      tick_after(10);
      if (done === 1'b1) dcnt++;
      if (i == 1) begin checks++; if (posx !== 10'd239) begin errs++; $display("FAIL full_out1: got %0d want 239", posx); end end
      if (i == 101) begin checks++; if (busy !== 1'b1 || posx !== 10'd639) begin errs++; $display("FAIL full_out101: busy=%b posx=%0d want 1/639", busy, posx); end end
    end
    checks++; if ({posx, isplay, busy, done} !== {10'd640, 3'b001}) begin errs++; $display("FAIL full_end: posx=%0d isplay/busy/done=%b want 640/001", posx, {isplay, busy, done}); end
    step(0, 0, 0, 0);
    if (done === 1'b1) dcnt++;
    checks++; if (dcnt !== 1) begin errs++; $display("FAIL full_done_count: got %0d want 1", dcnt); end
  endtask

  task automatic test_skip_slide_in();
    step(0, 1, 0, 0);
    repeat (10) tick_after(2);
    checks++; if (posx !== 10'd600) begin errs++; $display("FAIL skip_pre: got %0d want 600", posx); end
    step(0, 0, 1, 0);
    tick_after(3);
    checks++; if (posx !== 10'd600 || isplay !== 1'b1) begin errs++; $display("FAIL skip_enter_out: posx=%0d isplay=%b want 600/1", posx, isplay); end
    repeat (9) tick_after(2);
    checks++; if (posx !== 10'd636 || done !== 1'b0) begin errs++; $display("FAIL skip_out9: posx=%0d done=%b want 636/0", posx, done); end
    tick_after(2);
    checks++; if (posx !== 10'd640 || done !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL skip_out10: posx=%0d done=%b busy=%b want 640/1/0", posx, done, busy); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_coincident();
    step(1, 1, 0, 0);
    checks++; if (posx !== 10'd640 || busy !== 1'b1) begin errs++; $display("FAIL coinc_start: posx=%0d busy=%b want 640/1", posx, busy); end
    tick_after(2);
    checks++; if (posx !== 10'd636) begin errs++; $display("FAIL coinc_first_step: got %0d want 636", posx); end
    repeat (101) tick_after(2);
    repeat (3) tick_after(2);
    step(1, 0, 1, 0);
    checks++; if (posx !== 10'd235 || isplay !== 1'b1) begin errs++; $display("FAIL coinc_skip_tick: posx=%0d isplay=%b want 235/1", posx, isplay); end
    tick_after(2);
    checks++; if (posx !== 10'd239) begin errs++; $display("FAIL coinc_out_step: got %0d want 239", posx); end
    finish_out();
  endtask

  task automatic test_ignored();
    int n;
    run_to_hold();
    repeat (5) tick_after(2);
    step(0, 1, 0, 0);
    checks++; if (posx !== 10'd235 || busy !== 1'b1) begin errs++; $display("FAIL ign_start_hold: posx=%0d busy=%b want 235/1", posx, busy); end
    n = 5;
    while (posx === 10'd235 && n < 300) begin tick_after(2); n++; end
    checks++; if (n !== 121) begin errs++; $display("FAIL ign_hold_len: got %0d ticks want 121", n); end
    finish_out();
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    checks++; if (busy !== 1'b0 || isplay !== 1'b0) begin errs++; $display("FAIL ign_skip_idle: busy=%b isplay=%b want 0/0", busy, isplay); end
    run_to_hold();
    n = 0;
    while (posx === 10'd235 && n < 300) begin tick_after(2); n++; end
    checks++; if (n !== 121) begin errs++; $display("FAIL ign_full_hold_after_skip: got %0d ticks want 121", n); end
    finish_out();
  endtask

  task automatic test_no_tearing();
    step(0, 1, 0, 0);
    repeat (5) tick_after(2);
    repeat (1000) step(0, 0, 0, 0);
    checks++; if (posx !== 10'd620 || isplay !== 1'b1) begin errs++; $display("FAIL tear_hold: posx=%0d isplay=%b want 620/1", posx, isplay); end
    finish_out();
  endtask

  task automatic test_random();
    bit t, s, k, r;
    for (int c = 0; c < 6000; c++) begin
      t = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 39) == 0);
      k = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 2999) == 0);
      step(t, s, k, r);
      checks++;
      if (posx !== 10'(m_x) || posy !== 9'd100 || isplay !== m_vis || busy !== (m_phase != 0) || done !== m_done) begin
        errs++;
        $display("FAIL rand_cyc%0d: posx=%0d posy=%0d isplay=%b busy=%b done=%b want %0d/100/%b/%b/%b",
                 c, posx, posy, isplay, busy, done, m_x, m_vis, (m_phase != 0), m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_skip_slide_in();
    test_coincident();
    test_ignored();
    test_no_tearing();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ack_banner_seq.md
Name: ack_banner_seq

Overview:
- Sequencer for the acknowledgement banner sprite: drives its posx/posy/isplay inputs to slide the banner in from the right edge, hold it with a blink, then slide it out.
- Sits between the game-state logic (start/skip pulses) and the banner sprite renderer.
- All position changes happen only on frame_tick (vertical blanking), so the banner never tears mid-frame.

Parameters:
- WIDTH, 170, banner width in pixels
- HOME_X, 235, resting left-corner x ((640-170)/2)
- HOME_Y, 100, banner top-corner y (constant throughout)
- OFF_X, 640, off-screen x (first column past visible area)
- STEP, 4, pixels moved per frame during slides
- HOLD_FRAMES, 120, frames spent in HOLD
- BLINK_PERIOD, 16, blink period in frames (power of two, ≥2)

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- start  in  1  one-cycle request to run the banner sequence
- skip  in  1  one-cycle request to end HOLD/SLIDE_IN early
- posx  out  10  banner left x to renderer
- posy  out  9  banner top y to renderer
- isplay  out  1  banner enable to renderer
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when sequence completes

Behaviour:
- One clock, clk; reset synchronous, active-high, port rst. All outputs are registered.
- Reset values: state=IDLE, posx=OFF_X, posy=HOME_Y, isplay=0, busy=0, done=0, skip_pend=0, hold_cnt=0. Reset mid-sequence aborts immediately to these values.
- States: IDLE, SLIDE_IN, HOLD, SLIDE_OUT.
- IDLE:
  - start=1 → next cycle: SLIDE_IN, posx=OFF_X, isplay=1, busy=1, skip_pend=0.
  - A frame_tick coincident with start is not counted as a step.
  - skip is ignored.
- SLIDE_IN, on each frame_tick:
  - if posx-HOME_X ≤ STEP: posx=HOME_X, go to HOLD, hold_cnt=0.
  - else posx=posx-STEP.
  - isplay stays 1.
- HOLD, on each frame_tick:
  - hold_cnt increments.
  - isplay = (hold_cnt_next mod BLINK_PERIOD) < BLINK_PERIOD/2.
  - if hold_cnt_next == HOLD_FRAMES or skip_pend: go to SLIDE_OUT, isplay=1, skip_pend=0.
  - hold_cnt is wide enough for HOLD_FRAMES without wrap (8 bits for the default).
- skip in SLIDE_IN or HOLD sets skip_pend. It takes effect at the next frame_tick, which moves to SLIDE_OUT at the current posx (no further slide-in step).
  - skip coincident with frame_tick counts for that tick.
  - skip in SLIDE_OUT or IDLE is ignored.
- SLIDE_OUT, on each frame_tick:
  - if posx+STEP ≥ OFF_X: posx=OFF_X, isplay=0, busy=0, done=1 for exactly one cycle, go to IDLE.
  - else posx=posx+STEP.
- start while busy=1 is ignored (no restart, no queueing).
- Arithmetic: comparisons are done in 11 bits so posx+STEP never wraps. posx never leaves [HOME_X, OFF_X].
- posy = HOME_Y at all times (a registered constant; the port exists for the renderer interface).
- Latency: an input sampled at edge N is visible on outputs after edge N. No combinational path from inputs to outputs.

Decomposition:
- Shared package (game_pkg):
  - state enum {IDLE, SLIDE_IN, HOLD, SLIDE_OUT}
  - screen constants SCREEN_W=640, SCREEN_H=480
- One natural sub-module: banner_hold_timer.
  - Contains hold_cnt, blink phase and the expiry flag.
  - Inputs: clk, rst, clear, tick.
  - Outputs: blink_on, expired.
- The FSM and position arithmetic stay in ack_banner_seq.

Test Plan:
- Reset check: assert rst 3 cycles during HOLD → posx=640, posy=100, isplay=0, busy=0, done=0 on the cycle after rst.
- Full run, no skip: start, then frame_ticks spaced 10 cycles. After tick 101 posx=236; tick 102 posx=235 and state HOLD. 120 HOLD ticks, with isplay low for hold_cnt 8–15, 24–31, …. Then 102 ticks to posx=640, done pulses once, busy falls in the same cycle.
- Skip mid slide-in: skip after tick 10 (posx=600) → next tick enters SLIDE_OUT at posx=600; after 10 more ticks posx=640 and done=1.
- Coincident events: start+frame_tick same cycle → posx stays 640 that cycle. skip+frame_tick in HOLD → SLIDE_OUT on that tick.
- Ignored requests: start during HOLD → no change to posx or hold_cnt. skip in IDLE → next start runs the full 120-frame HOLD.
- No tearing: toggle clk for 1000 cycles without frame_tick while in SLIDE_IN → posx constant.
